// File: rtl/mm2s_read_sequencer.sv
// Command front-end for the MM2S reader: turns one (base, burst count) command into a paced
// sequence of start_read pulses and runs the reader's sw_reset handshake on abort.
module mm2s_read_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXI_BURST_LEN  = 256,
    parameter int C_COUNT_WIDTH      = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [C_COUNT_WIDTH-1:0]      cmd_num_bursts,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [C_COUNT_WIDTH-1:0]      bursts_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] read_address,
    output logic                          start_read,
    input  logic                          output_idle,
    output logic                          sw_reset,
    input  logic                          sw_reset_ok,
    output logic [2:0]                    dbg_state
);

    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_AXI_DATA_WIDTH / 8;
    localparam logic [AW-1:0] BURST_INC  = AW'(BURST_BYTES);
    localparam logic [AW-1:0] ALIGN_MASK = ~(BURST_INC - AW'(1));

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_BUSY  = 3'd2,
        S_WAIT_IDLE  = 3'd3,
        S_DONE       = 3'd4,
        S_ABORT      = 3'd5,
        S_ABORT_WAIT = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [C_COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [C_COUNT_WIDTH-1:0] bursts_done_q, bursts_done_d;
    logic [AW-1:0]            read_address_q, read_address_d;
    logic                     start_read_q, start_read_d;
    logic                     sw_reset_q, sw_reset_d;
    logic                     done_q, done_d;
    logic                     aborted_q, aborted_d;

    // Handshake: a command transfers on a rising ACLK edge where cmd_valid && cmd_ready;
    // cmd_ready is high exactly in IDLE and does not depend on cmd_valid.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        bursts_done_d  = bursts_done_q;
        read_address_d = read_address_q;
        start_read_d   = 1'b0;
        done_d         = 1'b0;
        aborted_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d        = cmd_base_addr & ALIGN_MASK;
                    remaining_d   = cmd_num_bursts;
                    bursts_done_d = '0;
                    state_d       = (cmd_num_bursts == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (output_idle) begin
                    start_read_d   = 1'b1;
                    read_address_d = addr_q;
                    state_d        = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // The reader only drops idle once it has sampled start_read.
                if (abort) begin
                    state_d = S_ABORT;
                end else if (!output_idle) begin
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (output_idle) begin
                    addr_d        = addr_q + BURST_INC;
                    remaining_d   = remaining_q - 1'b1;
                    bursts_done_d = bursts_done_q + 1'b1;
                    state_d       = (remaining_d == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                if (sw_reset_ok) begin
                    state_d = S_ABORT_WAIT;
                end
            end
            S_ABORT_WAIT: begin
                if (!sw_reset_ok) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        sw_reset_d = (state_d == S_ABORT);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            bursts_done_q  <= '0;
            read_address_q <= '0;
            start_read_q   <= 1'b0;
            sw_reset_q     <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            bursts_done_q  <= bursts_done_d;
            read_address_q <= read_address_d;
            start_read_q   <= start_read_d;
            sw_reset_q     <= sw_reset_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign bursts_done  = bursts_done_q;
    assign read_address = read_address_q;
    assign start_read   = start_read_q;
    assign sw_reset     = sw_reset_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mm2s_read_sequencer.sv
// Bench for mm2s_read_sequencer: behavioural MM2S reader model, event monitor and
// per-scenario tasks checking against addresses computed from the command.
`timescale 1ns/1ps
module tb_mm2s_read_sequencer;

    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int BL          = 256;
    localparam int CW          = 16;
    localparam int BURST_BYTES = BL * DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [CW-1:0] cmd_num_bursts = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          abort = 1'b0;
    logic          busy, done, aborted;
    logic [CW-1:0] bursts_done;
    logic [AW-1:0] read_address;
    logic          start_read;
    logic          output_idle = 1'b1;
    logic          sw_reset;
    logic          sw_reset_ok = 1'b0;
    logic [2:0]    dbg_state;

    mm2s_read_sequencer #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW),
        .C_M_AXI_BURST_LEN(BL), .C_COUNT_WIDTH(CW)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_base_addr(cmd_base_addr), .cmd_num_bursts(cmd_num_bursts),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .bursts_done(bursts_done),
        .read_address(read_address), .start_read(start_read),
        .output_idle(output_idle), .sw_reset(sw_reset), .sw_reset_ok(sw_reset_ok),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // monitor results (written only by the monitor/reader process)
    int            n_start = 0, n_done = 0, n_abort = 0, viol = 0, sw_high_cnt = 0;
    int            start_cyc_q[$];
    int            done_cyc_q[$];
    int            abort_cyc_q[$];
    logic [AW-1:0] got_addr_q[$];
    int            ok_fall_cyc = 0;

    // reader knobs (written only by the stimulus tasks)
    int hold_seq = 0, hold_len = 0, busy_min = 1, busy_max = 6, sw_target = 2;

    // reader private state
    int hold_seen = 0, hold_cnt = 0, rd_busy = 0, sw_wait = 0;
    bit rd_pending = 1'b0;

    // Reader model: samples start_read, goes busy one cycle later for a random time,
    // answers sw_reset with sw_reset_ok after sw_target cycles, clears it after sw_reset drops.
    always @(negedge ACLK) begin
        if (start_read === 1'b1) begin
            n_start++;
            got_addr_q.push_back(read_address);
            start_cyc_q.push_back(cyc);
            if (!output_idle || rd_pending) viol++;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc_q.push_back(cyc);
        end
        if (aborted === 1'b1) begin
            n_abort++;
            abort_cyc_q.push_back(cyc);
        end
        if (sw_reset === 1'b1) sw_high_cnt++;

        if (!ARESETN) begin
            rd_pending = 1'b0; rd_busy = 0; hold_cnt = 0; hold_seen = hold_seq;
            sw_wait = 0; sw_reset_ok = 1'b0; output_idle = 1'b1;
        end else if (sw_reset === 1'b1) begin
            rd_pending = 1'b0; rd_busy = 0; output_idle = 1'b1;
            if (!sw_reset_ok) begin
                sw_wait++;
                if (sw_wait >= sw_target) sw_reset_ok = 1'b1;
            end
        end else if (sw_reset_ok) begin
            sw_reset_ok = 1'b0;
            sw_wait = 0;
            ok_fall_cyc = cyc;
        end else begin
            if (hold_seq != hold_seen) begin
                hold_seen = hold_seq;
                hold_cnt = hold_len;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
            end
            if (rd_busy > 0) rd_busy--;
            if (rd_pending) begin
                rd_pending = 1'b0;
                rd_busy = $urandom_range(busy_max, busy_min);
            end
            if (start_read === 1'b1) rd_pending = 1'b1;
            output_idle = (rd_busy == 0 && hold_cnt == 0);
        end
    end

    task automatic step();
        @(negedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({cmd_ready, busy, start_read, sw_reset, done, aborted} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {cmd_ready, busy, start_read, sw_reset, done, aborted});
        end
        n_cmp++;
        if (read_address !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %h want 0", read_address);
        end
        n_cmp++;
        if (bursts_done !== '0) begin
            n_fail++; $display("FAIL reset_bursts: got %0d want 0", bursts_done);
        end
        ARESETN = 1'b1;
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    // One command end to end; hold>0 keeps the reader non-idle for that many cycles.
    task automatic test_transfer(input logic [AW-1:0] base, input int n, input int hold,
                                 input bit abort_at_accept, input string name);
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] a0;
        int s0, d0, v0, c0, w, got_n;
        a0 = base - (base % BURST_BYTES);
        for (int i = 0; i < n; i++) exp_q.push_back(a0 + i * BURST_BYTES);
        s0 = n_start; d0 = n_done; v0 = viol;

        if (hold > 0) begin
            hold_len = hold;
            hold_seq++;
        end
        cmd_base_addr = base;
        cmd_num_bursts = CW'(n);
        cmd_valid = 1'b1;
        abort = abort_at_accept;
        c0 = cyc;
        step();
        cmd_valid = 1'b0;
        abort = 1'b0;
        cmd_base_addr = $urandom;
        n_cmp++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_accept: busy=%b ready=%b want busy=1 ready=0", name, busy, cmd_ready);
        end

        w = 0;
        while (n_done == d0 && w < 4000) begin
            step();
            w++;
        end
        repeat (3) step();
        n_cmp++;
        if (n_done - d0 != 1) begin
            n_fail++; $display("FAIL %s_done_cnt: got %0d pulses want 1", name, n_done - d0);
        end
        got_n = n_start - s0;
        n_cmp++;
        if (got_n != n) begin
            n_fail++; $display("FAIL %s_start_cnt: got %0d want %0d", name, got_n, n);
        end
        for (int i = 0; i < n && i < got_n; i++) begin
            n_cmp++;
            if (got_addr_q[s0 + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_addr%0d: got %h want %h", name, i, got_addr_q[s0 + i], exp_q[i]);
            end
        end
        n_cmp++;
        if (bursts_done !== CW'(n)) begin
            n_fail++; $display("FAIL %s_bursts_done: got %0d want %0d", name, bursts_done, n);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end_idle: ready=%b busy=%b want 1/0", name, cmd_ready, busy);
        end
        n_cmp++;
        if (viol != v0) begin
            n_fail++; $display("FAIL %s_pacing: got %0d early start_read want 0", name, viol - v0);
        end
        if (n == 0 && n_done > d0) begin
            n_cmp++;
            if (done_cyc_q[d0] - c0 != 2) begin
                n_fail++; $display("FAIL %s_done_lat: got %0d want 2", name, done_cyc_q[d0] - c0);
            end
        end
        if (n > 0 && n_done > d0 && got_n > 0) begin
            n_cmp++;
            if (done_cyc_q[d0] <= start_cyc_q[n_start - 1]) begin
                n_fail++;
                $display("FAIL %s_done_order: done@%0d last start@%0d want done later",
                         name, done_cyc_q[d0], start_cyc_q[n_start - 1]);
            end
        end
        if (hold > 0 && got_n > 0) begin
            n_cmp++;
            if (start_cyc_q[s0] - c0 != hold + 2) begin
                n_fail++;
                $display("FAIL %s_deferred: got %0d want %0d", name, start_cyc_q[s0] - c0, hold + 2);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            busy_max = $urandom_range(6, 1);
            test_transfer($urandom, $urandom_range(4, 1), 0, 1'b0, "random");
        end
        busy_max = 6;
    endtask

    task automatic test_abort();
        int s0, d0, a0, sh0, w;
        busy_min = 4;
        sw_target = $urandom_range(4, 1);
        s0 = n_start; d0 = n_done; a0 = n_abort;
        cmd_base_addr = 32'h4000_0000;
        cmd_num_bursts = CW'(3);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        w = 0;
        while (!(n_start == s0 + 2 && output_idle == 1'b0) && w < 2000) begin
            step();
            w++;
        end
        step();
        sh0 = sw_high_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (sw_reset !== 1'b1) begin
            n_fail++; $display("FAIL abort_sw_rise: got %b want 1", sw_reset);
        end
        w = 0;
        while (n_abort == a0 && w < 2000) begin
            step();
            w++;
        end
        repeat (20) step();
        n_cmp++;
        if (n_abort - a0 != 1) begin
            n_fail++; $display("FAIL abort_pulse_cnt: got %0d want 1", n_abort - a0);
        end
        if (n_abort > a0) begin
            n_cmp++;
            if (abort_cyc_q[a0] != ok_fall_cyc + 1) begin
                n_fail++;
                $display("FAIL abort_pulse_time: got %0d want %0d", abort_cyc_q[a0], ok_fall_cyc + 1);
            end
        end
        n_cmp++;
        if (sw_high_cnt - sh0 != sw_target) begin
            n_fail++;
            $display("FAIL abort_sw_len: got %0d cycles want %0d", sw_high_cnt - sh0, sw_target);
        end
        n_cmp++;
        if (n_start - s0 != 2) begin
            n_fail++; $display("FAIL abort_start_cnt: got %0d want 2", n_start - s0);
        end
        n_cmp++;
        if (bursts_done !== CW'(1)) begin
            n_fail++; $display("FAIL abort_bursts_done: got %0d want 1", bursts_done);
        end
        n_cmp++;
        if (n_done != d0 || cmd_ready !== 1'b1 || sw_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_end: done=%0d ready=%b sw_reset=%b want 0/1/0",
                     n_done - d0, cmd_ready, sw_reset);
        end
        busy_min = 1;
        sw_target = 2;
    endtask

    task automatic test_reset_mid();
        int s0, w;
        sw_target = 1000;
        s0 = n_start;
        cmd_base_addr = 32'h5000_0000;
        cmd_num_bursts = CW'(4);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        w = 0;
        while (n_start == s0 && w < 2000) begin
            step();
            w++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (sw_reset !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_sw_held: got %b want 1", sw_reset);
        end
        ARESETN = 1'b0;
        step();
        n_cmp++;
        if ({sw_reset, busy, cmd_ready, start_read, done, aborted} !== 6'b001000) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got %b want 001000",
                     {sw_reset, busy, cmd_ready, start_read, done, aborted});
        end
        n_cmp++;
        if (read_address !== '0 || bursts_done !== '0) begin
            n_fail++;
            $display("FAIL rstmid_regs: addr=%h bursts=%0d want 0/0", read_address, bursts_done);
        end
        ARESETN = 1'b1;
        sw_target = 2;
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1 || sw_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: ready=%b sw_reset=%b want 1/0", cmd_ready, sw_reset);
        end
    endtask

    initial begin
        test_reset();
        test_transfer(32'h1000_0000, 3, 0, 1'b0, "basic");
        test_transfer(32'h1000_0123, 1, 0, 1'b0, "unaligned");
        test_transfer(32'h1000_0000, 0, 0, 1'b0, "zero");
        test_transfer(32'hFFFF_FC00, 2, 0, 1'b0, "wrap");
        test_transfer(32'h2000_0000, 2, 5, 1'b0, "hold");
        test_transfer(32'h3000_0040, 2, 0, 1'b1, "abort_idle");
        test_random();
        test_abort();
        test_transfer(32'h6000_07FF, 2, 0, 1'b0, "post_abort");
        test_reset_mid();
        test_transfer(32'h7000_0000, 1, 0, 1'b0, "post_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
